// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode names and baud arithmetic.
package uart_pkg;

  localparam int unsigned CNT_BAUD_W = 20;
  localparam int unsigned CNT_BIT_W  = 3;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    CHECK = 5'b01000,
    STOP  = 5'b10000
  } uart_state_e;

  localparam string PARITY_NONE = "None";
  localparam string PARITY_ODD  = "Odd";
  localparam string PARITY_EVEN = "Even";

  function automatic int unsigned bit_cycles(input int unsigned clock, input int unsigned baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus an extra stage for falling-edge detection; all flops reset high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall_c
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync   = sync_q;
  assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB first, optional parity, 1 stop; one-cycle strobe per byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK     = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter string       CHECK_BIT = "None"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_data_vld,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned BIT_CYC  = bit_cycles(CLOCK, BAUD);
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam bit          PAR_EN   = (CHECK_BIT != PARITY_NONE);
  localparam bit          PAR_ODD  = (CHECK_BIT == PARITY_ODD);

  logic sync, fall_c;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (rx),
    .sync   (sync),
    .fall_c (fall_c)
  );

  uart_state_e           state_q, state_d;
  logic [CNT_BAUD_W-1:0] cnt_baud_q, cnt_baud_d;
  logic [CNT_BIT_W-1:0]  cnt_bit_q, cnt_bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic                  vld_q, vld_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q, busy_d;

  logic sample_c, end_bit_c, exp_par_c;

  assign sample_c  = (cnt_baud_q == CNT_BAUD_W'(HALF_CYC - 1));
  assign end_bit_c = (cnt_baud_q == CNT_BAUD_W'(BIT_CYC - 1));
  assign exp_par_c = PAR_ODD ? ~^shift_q : ^shift_q;

  // Next-state, bit counters and output strobes
  always_comb begin
    state_d    = state_q;
    cnt_baud_d = cnt_baud_q + CNT_BAUD_W'(1);
    cnt_bit_d  = cnt_bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    rx_data_d  = rx_data_q;
    vld_d      = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_bit_d = '0;
        if (fall_c) state_d = START;
      end
      START: begin
        if (sample_c && sync) state_d = IDLE;
        else if (end_bit_c)   state_d = DATA;
      end
      DATA: begin
        if (sample_c) shift_d[cnt_bit_q] = sync;
        if (end_bit_c) begin
          cnt_bit_d = cnt_bit_q + CNT_BIT_W'(1);
          if (cnt_bit_q == CNT_BIT_W'(DATA_W - 1)) state_d = PAR_EN ? CHECK : STOP;
        end
      end
      CHECK: begin
        if (sample_c)  par_bit_d = sync;
        if (end_bit_c) state_d   = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (sample_c) begin
          state_d   = IDLE;
          rx_data_d = shift_q;
          vld_d     = 1'b1;
          ferr_d    = ~sync;
          perr_d    = PAR_EN && (par_bit_q != exp_par_c);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d != state_q || end_bit_c) cnt_baud_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_baud_q <= '0;
      cnt_bit_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      rx_data_q  <= '0;
      vld_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_baud_q <= cnt_baud_d;
      cnt_bit_q  <= cnt_bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      rx_data_q  <= rx_data_d;
      vld_q      <= vld_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_data_vld = vld_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign busy        = busy_q;

endmodule
